// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// gcd_pkg : shared types and defaults for the GCD datapath and its controller
// Revision: 1.0
// ============================================================================
package gcd_pkg;

   localparam int GCD_WIDTH = 8;
   localparam int GCD_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_RUN    = 2'd2,
      ST_HOLD   = 2'd3
   } dp_state_t;

   // Controller encoding, kept here so benches can probe either block by name
   typedef enum logic [2:0] {
      CS_WAIT = 3'd0,
      CS_NE   = 3'd1,
      CS_WISG = 3'd2,
      CS_SUBA = 3'd3,
      CS_SUBB = 3'd4,
      CS_RES  = 3'd5
   } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_datapath_if.sv
`default_nettype none
// ============================================================================
// gcd_datapath_if : operand/result handshakes plus controller command lines
// Revision: 1.0
// ============================================================================
interface gcd_datapath_if
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int CNT_W = GCD_CNT_W
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             start;
   logic             ANEB;
   logic             AGTB;
   logic             sub_A;
   logic             sub_B;
   logic             result;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] gcd_out;
   logic [CNT_W-1:0] iter_count;
   logic             zero_bypass;
   logic             proto_err;

   modport master (
      output in_valid, in_a, in_b, sub_A, sub_B, result, out_ready,
      input  in_ready, start, ANEB, AGTB, out_valid, gcd_out, iter_count,
             zero_bypass, proto_err
   );

   modport slave (
      input  in_valid, in_a, in_b, sub_A, sub_B, result, out_ready,
      output in_ready, start, ANEB, AGTB, out_valid, gcd_out, iter_count,
             zero_bypass, proto_err
   );
endinterface
`default_nettype wire

// File: rtl/gcd_operand_regs.sv
`default_nettype none
// ============================================================================
// gcd_operand_regs : A/B operand registers, subtract muxes and comparators
// Revision: 1.0
// ============================================================================
module gcd_operand_regs #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_load,
   input  wire logic [WIDTH-1:0] i_a,
   input  wire logic [WIDTH-1:0] i_b,
   input  wire logic             i_sub_a,
   input  wire logic             i_sub_b,
   output logic      [WIDTH-1:0] o_a,
   output logic                  o_aneb,
   output logic                  o_agtb
);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_diff_ab;
   logic [WIDTH-1:0] w_diff_ba;

   assign w_diff_ab = r_a - r_b;
   assign w_diff_ba = r_b - r_a;

   // Subtract strobes arrive already qualified, so at most one is ever high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
      end else if (i_load) begin
         r_a <= i_a;
         r_b <= i_b;
      end else begin
         if (i_sub_a) r_a <= w_diff_ab;
         if (i_sub_b) r_b <= w_diff_ba;
      end
   end

   assign o_a    = r_a;
   assign o_aneb = (r_a != r_b);
   assign o_agtb = (r_a > r_b);

endmodule
`default_nettype wire

// File: rtl/gcd_datapath.sv
`default_nettype none
// ============================================================================
// gcd_datapath : operand/result stage wrapped around the GCD controller
// Revision: 1.0
// ============================================================================
module gcd_datapath
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int CNT_W = GCD_CNT_W
) (
   input wire logic      clk,
   input wire logic      rst_n,
   gcd_datapath_if.slave bus
);

   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   dp_state_t        r_state;
   dp_state_t        w_state_nxt;
   logic [WIDTH-1:0] r_gcd;
   logic [CNT_W-1:0] r_iter;
   logic             r_zero_bypass;
   logic             r_proto_err;

   logic             w_in_ready;
   logic             w_start;
   logic             w_out_valid;
   logic             w_run;
   logic             w_in_fire;
   logic             w_zero_op;
   logic             w_sub_a;
   logic             w_sub_b;
   logic             w_any_sub;
   logic             w_perr_set;
   logic [WIDTH-1:0] w_a;
   logic             w_aneb;
   logic             w_agtb;

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_start     = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_nxt = w_zero_op ? ST_HOLD : ST_LAUNCH;
         end
         ST_LAUNCH: begin
            w_start     = 1'b1;
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (bus.result) w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   assign w_run     = (r_state == ST_RUN);
   assign w_in_fire = w_in_ready & bus.in_valid;
   // A zero operand would make the subtractive loop spin forever
   assign w_zero_op = (bus.in_a == '0) | (bus.in_b == '0);
   assign w_any_sub = bus.sub_A | bus.sub_B;
   assign w_sub_a   = w_run & bus.sub_A & ~bus.sub_B & ~bus.result;
   assign w_sub_b   = w_run & bus.sub_B & ~bus.sub_A & ~bus.result;
   assign w_perr_set = (~w_run & (w_any_sub | bus.result))
                     | (bus.sub_A & bus.sub_B)
                     | (w_any_sub & bus.result);

   gcd_operand_regs #(
      .WIDTH (WIDTH)
   ) u_operand_regs (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_in_fire),
      .i_a     (bus.in_a),
      .i_b     (bus.in_b),
      .i_sub_a (w_sub_a),
      .i_sub_b (w_sub_b),
      .o_a     (w_a),
      .o_aneb  (w_aneb),
      .o_agtb  (w_agtb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gcd         <= '0;
         r_iter        <= '0;
         r_zero_bypass <= 1'b0;
         r_proto_err   <= 1'b0;
      end else begin
         if (w_in_fire) begin
            r_iter        <= '0;
            r_zero_bypass <= w_zero_op;
            if (w_zero_op) r_gcd <= bus.in_a | bus.in_b;
         end else begin
            if ((w_sub_a | w_sub_b) && !(&r_iter)) r_iter <= r_iter + c_cnt_one;
            if (w_run && bus.result) r_gcd <= w_a;
         end
         if (w_perr_set) r_proto_err <= 1'b1;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.start       = w_start;
   assign bus.out_valid   = w_out_valid;
   assign bus.ANEB        = w_aneb;
   assign bus.AGTB        = w_agtb;
   assign bus.gcd_out     = r_gcd;
   assign bus.iter_count  = r_iter;
   assign bus.zero_bypass = r_zero_bypass;
   assign bus.proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_gcd_datapath.sv
`default_nettype none
// ============================================================================
// tb_gcd_datapath : directed checks of the GCD operand/result stage
// Revision: 1.0
// ============================================================================
module tb_gcd_datapath;
   import gcd_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   gcd_datapath_if #(.WIDTH(8), .CNT_W(8)) bus ();

   gcd_datapath #(
      .WIDTH (8),
      .CNT_W (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"},  32'(bus.in_ready), 1);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_start"},     32'(bus.start), 0);
      chk({tag, "_gcd"},       32'(bus.gcd_out), 0);
      chk({tag, "_iter"},      32'(bus.iter_count), 0);
      chk({tag, "_zb"},        32'(bus.zero_bypass), 0);
      chk({tag, "_perr"},      32'(bus.proto_err), 0);
      chk({tag, "_aneb"},      32'(bus.ANEB), 0);
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge
   task automatic send(input logic [7:0] a, input logic [7:0] b);
      int n;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 32'(n < 100), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic launch(input logic [7:0] a, input logic [7:0] b);
      send(a, b);
      chk("start_high", 32'(bus.start), 1);
      @(negedge clk);
      chk("start_one_cycle", 32'(bus.start), 0);
   endtask

   // Controller model: one NE cycle, then a WISG cycle issuing sub or result
   task automatic run_ctrl();
      int k;
      for (k = 0; k < 600; k++) begin
         @(negedge clk);
         if (!bus.ANEB) begin
            bus.result = 1'b1;
            @(negedge clk);
            bus.result = 1'b0;
            break;
         end
         if (bus.AGTB) bus.sub_A = 1'b1;
         else          bus.sub_B = 1'b1;
         @(negedge clk);
         bus.sub_A = 1'b0;
         bus.sub_B = 1'b0;
      end
      chk("ctrl_timeout", 32'(k < 600), 1);
   endtask

   task automatic check_result(input string tag, input logic [7:0] g,
                               input logic [7:0] it, input logic zb);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 1);
      chk({tag, "_gcd"},       32'(bus.gcd_out), 32'(g));
      chk({tag, "_iter"},      32'(bus.iter_count), 32'(it));
      chk({tag, "_zb"},        32'(bus.zero_bypass), 32'(zb));
      chk({tag, "_busy"},      32'(bus.in_ready), 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_drained"},   32'(bus.out_valid), 0);
      chk({tag, "_ready"},     32'(bus.in_ready), 1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.sub_A     = 1'b0;
      bus.sub_B     = 1'b0;
      bus.result    = 1'b0;
      bus.out_ready = 1'b0;

      #1 rst_n = 1'b0;
      #1 chk_reset_values("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      launch(8'd12, 8'd18);
      run_ctrl();
      check_result("g12_18", 8'd6, 8'd2, 1'b0);

      // Second pair waits behind the first result
      launch(8'd48, 8'd18);
      bus.in_valid = 1'b1;
      bus.in_a     = 8'd17;
      bus.in_b     = 8'd5;
      chk("b2b_blocked", 32'(bus.in_ready), 0);
      run_ctrl();
      check_result("g48_18", 8'd6, 8'd4, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("b2b_start", 32'(bus.start), 1);
      @(negedge clk);
      chk("b2b_start_low", 32'(bus.start), 0);
      run_ctrl();
      check_result("g17_5", 8'd1, 8'd6, 1'b0);

      send(8'd0, 8'd9);
      chk("z0_9_no_start", 32'(bus.start), 0);
      check_result("z0_9", 8'd9, 8'd0, 1'b1);
      send(8'd0, 8'd0);
      chk("z0_0_no_start", 32'(bus.start), 0);
      check_result("z0_0", 8'd0, 8'd0, 1'b1);

      launch(8'd7, 8'd7);
      run_ctrl();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(bus.out_valid), 1);
         chk("stall_gcd",   32'(bus.gcd_out), 7);
         chk("stall_ready", 32'(bus.in_ready), 0);
         @(negedge clk);
      end
      check_result("g7_7", 8'd7, 8'd0, 1'b0);

      chk("perr_clean", 32'(bus.proto_err), 0);
      launch(8'd20, 8'd8);
      bus.sub_A = 1'b1;
      bus.sub_B = 1'b1;
      @(negedge clk);
      bus.sub_A = 1'b0;
      bus.sub_B = 1'b0;
      chk("dual_sub_perr", 32'(bus.proto_err), 1);
      chk("dual_sub_iter", 32'(bus.iter_count), 0);
      chk("dual_sub_agtb", 32'(bus.AGTB), 1);
      run_ctrl();
      check_result("g20_8", 8'd4, 8'd3, 1'b0);
      chk("idle_aneb_pre", 32'(bus.ANEB), 0);
      bus.sub_A = 1'b1;
      @(negedge clk);
      bus.sub_A = 1'b0;
      chk("idle_sub_aneb", 32'(bus.ANEB), 0);
      chk("idle_sub_agtb", 32'(bus.AGTB), 0);
      chk("idle_sub_ready", 32'(bus.in_ready), 1);
      chk("idle_sub_perr", 32'(bus.proto_err), 1);
      launch(8'd9, 8'd6);
      run_ctrl();
      check_result("g9_6", 8'd3, 8'd2, 1'b0);
      chk("perr_sticky", 32'(bus.proto_err), 1);

      launch(8'd255, 8'd1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.sub_A = 1'b1;
         @(negedge clk);
         bus.sub_A = 1'b0;
      end
      chk("mid_run_iter", 32'(bus.iter_count), 2);
      #2 rst_n = 1'b0;
      #1 chk_reset_values("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      launch(8'd8, 8'd12);
      run_ctrl();
      check_result("g8_12", 8'd4, 8'd2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gcd_datapath.md
Name: gcd_datapath

Overview:
Operand/result stage that pairs with the GCD controller. It accepts an (A,B) operand pair over a valid/ready handshake and holds A and B in registers. It drives the controller's start, ANEB and AGTB inputs, and performs the subtractions the controller commands through sub_A and sub_B. On the controller's result pulse it captures the GCD and presents it downstream over a valid/ready handshake, together with the subtraction count.

Parameters:
WIDTH, 8, operand/result width in bits (unsigned)
CNT_W, 8, iteration counter width; counter saturates at all-ones

Ports:
clk  in  1  single clock, all state on posedge
rst_n  in  1  asynchronous active-low reset; shared with the controller's reset net (inverted as needed)
in_valid  in  1  operand pair valid
in_ready  out  1  stage can accept an operand pair
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
start  out  1  one-cycle launch pulse to controller
ANEB  out  1  A != B (combinational from registers)
AGTB  out  1  A > B (combinational from registers)
sub_A  in  1  controller: A <= A - B this edge
sub_B  in  1  controller: B <= B - A this edge
result  in  1  controller: A == B, GCD ready
out_valid  out  1  gcd_out/iter_count valid
out_ready  in  1  downstream accepts the result
gcd_out  out  WIDTH  GCD result
iter_count  out  CNT_W  number of subtractions performed (saturating)
zero_bypass  out  1  result was produced without the controller because an operand was 0
proto_err  out  1  sticky: illegal controller command seen

Behaviour:
- Reset (async assert, sync deassert at the system level): state IDLE, A=B=0, gcd_out=0, iter_count=0, start=0, out_valid=0, zero_bypass=0, proto_err=0. in_ready=1 after reset.
- FSM states IDLE, LAUNCH, RUN, HOLD.
- IDLE: in_ready=1. On in_valid, latch A=in_a, B=in_b, clear iter_count and zero_bypass.
  - If in_a==0 or in_b==0: gcd_out=in_a|in_b (gcd(0,0)=0), zero_bypass=1, go to HOLD. start is never raised in this case, because the subtractive loop would not terminate.
  - Otherwise go to LAUNCH.
- LAUNCH: start=1 for exactly one cycle, then go to RUN. The controller leaves its wait state on the falling edge of start.
- RUN:
  - sub_A only: A <= A-B.
  - sub_B only: B <= B-A.
  - Each accepted subtraction increments iter_count, saturating at 2^CNT_W-1.
  - On result: gcd_out <= A, go to HOLD. A sub command and result in the same cycle is illegal: the sub is ignored and proto_err is set.
- HOLD: out_valid=1. gcd_out, iter_count and zero_bypass are stable until out_ready, then return to IDLE. in_ready=0 while HOLD is occupied (single-entry buffer; no overlap).
- Outside RUN, sub_A, sub_B and result are ignored; any assertion sets proto_err.
- sub_A and sub_B asserted together: neither is applied, and proto_err is set.
- proto_err clears only on reset.
- Subtraction is unsigned WIDTH-bit. The controller only issues a sub for the larger operand, so no underflow occurs in legal operation. On illegal use, wrap-around is accepted and is not checked.
- Latency: accept at edge 0, start high during cycle 1, then the controller's NE/WISG cycles (2 per subtraction), then res. Zero-bypass: out_valid in the cycle after the accept.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. Any in-flight operand pair is lost.

Decomposition:
- Shared package gcd_pkg holds:
  - the FSM state encoding (2-bit: IDLE, LAUNCH, RUN, HOLD);
  - the default WIDTH and CNT_W;
  - the controller state encoding, shared with the controller for bench probing.
- One natural sub-module, gcd_operand_regs: the A/B registers, subtract muxes and comparators (ANEB/AGTB). The top level holds the handshake FSM, iteration counter and error logic.

Test Plan:
- (12,18) with out_ready=1 -> gcd_out=6, iter_count=2, zero_bypass=0; start high for exactly 1 cycle.
- (48,18) -> gcd_out=6, iter_count=4; (17,5) -> gcd_out=1, iter_count=6; back-to-back in_valid -> second pair accepted only after the first result handshake completes.
- (0,9) -> gcd_out=9, zero_bypass=1, start never asserted, out_valid 1 cycle after accept; (0,0) -> gcd_out=0.
- (7,7) -> gcd_out=7, iter_count=0; out_ready held low 5 cycles -> out_valid and gcd_out stable, in_ready=0 throughout.
- Force sub_A and sub_B high together in RUN, then force sub_A in IDLE -> A/B unchanged in both cases, proto_err=1 and remains set until rst_n.
- Assert rst_n=0 mid-RUN on (255,1) -> all outputs reset asynchronously; a following (8,12) pair returns gcd_out=4.
